// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-lane write enables, selectable read-during-write
// behaviour, optional output register and a post-reset zeroing sweep.
module ram_sdp_be #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR       = 8,
  parameter int BYTE_W     = 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int CLR_ON_RST = 1,
  localparam int NB        = WIDTH / BYTE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WIDTH-1:0] wd,
  input  logic [NB-1:0]    wbe,
  input  logic             re,
  input  logic [ADDR-1:0]  raddr,
  output logic [WIDTH-1:0] rd,
  output logic             rd_valid,
  output logic             busy
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR:0] DEPTH_W = (ADDR + 1)'(DEPTH);
  localparam logic [MEM_AW-1:0] LAST_W = MEM_AW'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q;
  logic [MEM_AW-1:0] clr_ptr_q;
  logic              busy_q;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0]  lane_mask_d;
  logic              waddr_ok_d;
  logic              raddr_ok_d;
  logic              port_wr_d;
  logic              clr_wr_d;
  logic              wr_en_d;
  logic [MEM_AW-1:0] wr_idx_d;
  logic [WIDTH-1:0]  wr_data_d;
  logic [NB-1:0]     wr_lanes_d;
  logic              rd_req_d;
  logic [WIDTH-1:0]  old_word_d;
  logic [WIDTH-1:0]  rd_word_d;

  logic              s1_valid_q;
  logic [WIDTH-1:0]  s1_data_q;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane_mask
      assign lane_mask_d[gi*BYTE_W +: BYTE_W] = {BYTE_W{wbe[gi]}};
    end
  endgenerate

  assign waddr_ok_d = ({1'b0, waddr} < DEPTH_W);
  assign raddr_ok_d = ({1'b0, raddr} < DEPTH_W);

  // Port writes and sweep writes are mutually exclusive: the sweep only runs while busy.
  assign port_wr_d  = we && !busy_q && !rst && waddr_ok_d && (|wbe);
  assign clr_wr_d   = (state_q == CLEAR) && !rst;
  assign wr_en_d    = port_wr_d || clr_wr_d;
  assign wr_idx_d   = clr_wr_d ? clr_ptr_q : waddr[MEM_AW-1:0];
  assign wr_data_d  = clr_wr_d ? '0 : wd;
  assign wr_lanes_d = clr_wr_d ? '1 : wbe;

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_lanes_d[b]) begin
          mem[wr_idx_d][b*BYTE_W +: BYTE_W] <= wr_data_d[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rd_req_d   = re && !busy_q;
  assign old_word_d = raddr_ok_d ? mem[raddr[MEM_AW-1:0]] : '0;

  // New-data mode forwards the merged word; old-data mode relies on the pre-edge array value.
  always_comb begin
    rd_word_d = old_word_d;
    if ((RDW_MODE != 0) && port_wr_d && (waddr == raddr)) begin
      rd_word_d = (wd & lane_mask_d) | (old_word_d & ~lane_mask_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_req_d;
      if (rd_req_d) begin
        s1_data_q <= rd_word_d;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic             s2_valid_q;
      logic [WIDTH-1:0] s2_data_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            s2_data_q <= s1_data_q;
          end
        end
      end

      assign rd       = s2_data_q;
      assign rd_valid = s2_valid_q;
    end else begin : g_no_out_reg
      assign rd       = s1_data_q;
      assign rd_valid = s1_valid_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLR_ON_RST != 0) ? CLEAR : READY;
      clr_ptr_q <= '0;
      busy_q    <= (CLR_ON_RST != 0);
    end else begin
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_W) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= READY;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: three configurations driven with shared directed vectors,
// checked every cycle against a word-array model plus literal expectations.
module tb_ram_sdp_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, re;
  logic [7:0]  waddr, raddr;
  logic [31:0] wd;
  logic [3:0]  wbe;

  logic [31:0] rd_a, rd_b, rd_c;
  logic        rv_a, rv_b, rv_c;
  logic        busy_a, busy_b, busy_c;

  // a: old-data, latency 1; b: new-data, latency 2; c: new-data, latency 1, DEPTH 200
  ram_sdp_be #(.WIDTH(32), .DEPTH(16), .ADDR(8), .BYTE_W(8), .RDW_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) u_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wd(wd), .wbe(wbe),
    .re(re), .raddr(raddr), .rd(rd_a), .rd_valid(rv_a), .busy(busy_a));
  ram_sdp_be #(.WIDTH(32), .DEPTH(16), .ADDR(8), .BYTE_W(8), .RDW_MODE(1), .OUT_REG(1), .CLR_ON_RST(1)) u_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wd(wd), .wbe(wbe),
    .re(re), .raddr(raddr), .rd(rd_b), .rd_valid(rv_b), .busy(busy_b));
  ram_sdp_be #(.WIDTH(32), .DEPTH(200), .ADDR(8), .BYTE_W(8), .RDW_MODE(1), .OUT_REG(0), .CLR_ON_RST(1)) u_c (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wd(wd), .wbe(wbe),
    .re(re), .raddr(raddr), .rd(rd_c), .rd_valid(rv_c), .busy(busy_c));

  int  dep_m [3] = '{16, 16, 200};
  bit  rdw_m [3] = '{1'b0, 1'b1, 1'b1};
  int  lat_m [3] = '{1, 2, 1};

  logic [31:0] mem_m [3][256];
  int          bc_m  [3];
  logic [31:0] erd_m [3];
  logic [31:0] pd_m  [3];
  bit          ev_m  [3];
  bit          pv_m  [3];
  bit          started = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what each RAM must show after the current rising edge.
  task automatic model_step();
    logic [31:0] mask, val;
    bit          rq;
    mask = {{8{wbe[3]}}, {8{wbe[2]}}, {8{wbe[1]}}, {8{wbe[0]}}};
    for (int i = 0; i < 3; i++) begin
      rq  = 1'b0;
      val = '0;
      if (rst) begin
        bc_m[i]  = dep_m[i];
        erd_m[i] = '0;
        ev_m[i]  = 1'b0;
        pv_m[i]  = 1'b0;
        pd_m[i]  = '0;
        for (int a = 0; a < 256; a++) mem_m[i][a] = '0;
      end else begin
        if (bc_m[i] > 0) begin
          bc_m[i]--;
        end else begin
          if (re) begin
            rq = 1'b1;
            if (int'(raddr) < dep_m[i]) begin
              val = mem_m[i][raddr];
              if (rdw_m[i] && we && waddr == raddr) val = (wd & mask) | (val & ~mask);
            end
          end
          if (we && int'(waddr) < dep_m[i])
            mem_m[i][waddr] = (wd & mask) | (mem_m[i][waddr] & ~mask);
        end
        if (lat_m[i] == 1) begin
          ev_m[i] = rq;
          if (rq) erd_m[i] = val;
        end else begin
          ev_m[i] = pv_m[i];
          if (pv_m[i]) erd_m[i] = pd_m[i];
          pv_m[i] = rq;
          pd_m[i] = val;
        end
      end
    end
    started = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_busy_a", busy_a, bc_m[0] > 0);
      chk("cyc_rv_a",   rv_a,   ev_m[0]);
      chk("cyc_rd_a",   rd_a,   erd_m[0]);
      chk("cyc_busy_b", busy_b, bc_m[1] > 0);
      chk("cyc_rv_b",   rv_b,   ev_m[1]);
      chk("cyc_rd_b",   rd_b,   erd_m[1]);
      chk("cyc_busy_c", busy_c, bc_m[2] > 0);
      chk("cyc_rv_c",   rv_c,   ev_m[2]);
      chk("cyc_rd_c",   rd_c,   erd_m[2]);
    end
  end

  initial begin
    int cnt_a, cnt_b, guard;
    rst = 1'b1; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; wd = '0; wbe = '0;
    cyc();
    cyc();
    chk("rst_rd_a", rd_a, 32'h0);
    chk("rst_rv_a", rv_a, 1'b0);
    chk("rst_busy_a", busy_a, 1'b1);

    // Clear sweep with writes and reads hammering the ports while a/b are busy
    rst = 1'b0; wbe = 4'hF; wd = 32'hFFFF_FFFF;
    cnt_a = 0; cnt_b = 0; guard = 0;
    while ((busy_a || busy_b || busy_c) && guard < 1000) begin
      we = busy_a; re = busy_a;
      waddr = 8'(guard % 16); raddr = 8'(guard % 16);
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      cyc();
      guard++;
    end
    we = 1'b0; re = 1'b0;
    chk("clear_timeout", guard < 1000, 1'b1);
    chk("busy_cycles_a", cnt_a, 16);
    chk("busy_cycles_b", cnt_b, 16);

    for (int a = 0; a < 16; a++) begin
      re = 1'b1; raddr = 8'(a);
      cyc();
      chk("clr_rd_a", rd_a, 32'h0);
      chk("clr_rv_a", rv_a, 1'b1);
    end
    re = 1'b0;
    cyc();
    cyc();

    // Byte enables
    we = 1'b1; waddr = 8'd5; wd = 32'h1122_3344; wbe = 4'hF;
    cyc();
    wd = 32'hAABB_CCDD; wbe = 4'b0101;
    cyc();
    we = 1'b0; re = 1'b1; raddr = 8'd5;
    cyc();
    re = 1'b0;
    chk("be_rd_a", rd_a, 32'h11BB_33DD);
    chk("be_rv_a", rv_a, 1'b1);
    chk("be_rv_b_early", rv_b, 1'b0);
    cyc();
    chk("be_rd_b", rd_b, 32'h11BB_33DD);
    chk("be_rv_b", rv_b, 1'b1);
    chk("be_rv_a_drop", rv_a, 1'b0);
    chk("be_rd_a_hold", rd_a, 32'h11BB_33DD);

    // Read during write on address 7
    we = 1'b1; re = 1'b1; waddr = 8'd7; raddr = 8'd7; wd = 32'hDEAD_BEEF; wbe = 4'b0011;
    cyc();
    we = 1'b0; re = 1'b0;
    chk("rdw_old_a", rd_a, 32'h0000_0000);
    chk("rdw_new_c", rd_c, 32'h0000_BEEF);
    cyc();
    chk("rdw_new_b", rd_b, 32'h0000_BEEF);
    re = 1'b1;
    cyc();
    re = 1'b0;
    chk("rdw_after_a", rd_a, 32'h0000_BEEF);
    chk("rdw_after_c", rd_c, 32'h0000_BEEF);
    cyc();
    chk("rdw_after_b", rd_b, 32'h0000_BEEF);

    // Pipelined reads through the output register
    wbe = 4'hF;
    for (int k = 0; k < 4; k++) begin
      we = 1'b1; waddr = 8'(k); wd = 32'hA0 + 32'(k);
      cyc();
    end
    we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      re = (k < 4); raddr = 8'(k);
      cyc();
      if (k == 0) begin
        chk("pipe_rv_b_k0", rv_b, 1'b0);
      end else if (k <= 4) begin
        chk("pipe_rv_b", rv_b, 1'b1);
        chk("pipe_rd_b", rd_b, 32'hA0 + 32'(k - 1));
      end else begin
        chk("pipe_rv_b_end", rv_b, 1'b0);
        chk("pipe_rd_b_hold", rd_b, 32'h0000_00A3);
      end
    end
    re = 1'b0;

    // Out-of-range addresses on the 200-word instance
    we = 1'b1; waddr = 8'd199; wd = 32'h1234_5678; wbe = 4'hF;
    cyc();
    waddr = 8'd210; wd = 32'h5A5A_5A5A;
    cyc();
    we = 1'b0; re = 1'b1; raddr = 8'd210;
    cyc();
    chk("oor_rd_c", rd_c, 32'h0);
    chk("oor_rv_c", rv_c, 1'b1);
    raddr = 8'd199;
    cyc();
    re = 1'b0;
    chk("oor_199_c", rd_c, 32'h1234_5678);

    // Reset while two reads are in flight, then again mid-sweep
    re = 1'b1; raddr = 8'd1;
    cyc();
    raddr = 8'd2;
    cyc();
    re = 1'b0; rst = 1'b1;
    cyc();
    chk("abort_rv_b", rv_b, 1'b0);
    chk("abort_rd_b", rd_b, 32'h0);
    chk("abort_busy_b", busy_b, 1'b1);
    rst = 1'b0;
    repeat (8) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cnt_b = 0; guard = 0;
    while ((busy_a || busy_b || busy_c) && guard < 1000) begin
      re = busy_b; raddr = 8'd3;
      if (busy_b) cnt_b++;
      cyc();
      guard++;
    end
    re = 1'b0;
    chk("clear2_timeout", guard < 1000, 1'b1);
    chk("busy_cycles_b2", cnt_b, 16);
    re = 1'b1; raddr = 8'd5;
    cyc();
    re = 1'b0;
    chk("post_clr_rd_a", rd_a, 32'h0);
    chk("post_clr_rv_a", rv_a, 1'b1);
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one independent read port on a single clock.
- Adds per-byte write enables, selectable read-during-write behaviour, an optional output register stage with a matching read-valid strobe, and a post-reset memory-clear sweep.
- Serves as the general storage primitive for buffers, register files and lookup tables, in place of the single-port RAM.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of BYTE_W.
- DEPTH, 256, number of words; DEPTH <= 2**ADDR.
- ADDR, 8, address width in bits.
- BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W lanes.
- RDW_MODE, 0, same-address read during write: 0 = old data, 1 = new (merged) data.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- CLR_ON_RST, 1, 1 = zero every word after reset; 0 = no clear, contents undefined.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst, input, 1, reset; synchronous, active-high.
- we, input, 1, write request.
- waddr, input, ADDR, write address.
- wd, input, WIDTH, write data.
- wbe, input, NB, byte-lane write enables; lane i = wd[i*BYTE_W +: BYTE_W].
- re, input, 1, read request.
- raddr, input, ADDR, read address.
- rd, output, WIDTH, read data; holds its last value between reads.
- rd_valid, output, 1, one-cycle strobe marking new data on rd.
- busy, output, 1, high while the clear sweep runs; requests are ignored while high.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rd=0, rd_valid=0, and every read pipeline stage is cleared.
  - Clear pointer set to 0.
  - busy=1 if CLR_ON_RST=1, else busy=0.
- FSM states: CLEAR, READY.
  - rst forces CLEAR when CLR_ON_RST=1, else READY.
  - In CLEAR, each cycle with rst=0 writes 0 to mem[ptr] and increments ptr.
  - After mem[DEPTH-1] is written, state becomes READY and busy drops on that same edge. busy is therefore high for exactly DEPTH cycles after rst deasserts.
  - rst asserted mid-clear restarts the sweep at 0.
- Gating: while busy=1, we and re are ignored. No memory write from ports, no rd_valid, rd unchanged.
- Write (READY, we=1):
  - At the edge, each lane i with wbe[i]=1 updates mem[waddr] lane i; lanes with wbe[i]=0 are untouched.
  - we=1 with wbe=0 is a no-op.
- Read (READY, re=1):
  - OUT_REG=0: rd=mem[raddr] and rd_valid=1 after edge N+1.
  - OUT_REG=1: rd and rd_valid appear after edge N+2.
  - Back-to-back reads are fully pipelined, one result per cycle.
  - rd_valid=0 in cycles with no completing read. rd holds its value.
- Read-during-write (re=we=1, raddr==waddr, READY):
  - RDW_MODE=0: rd returns the word before the write.
  - RDW_MODE=1: rd returns the merged word, i.e. new lanes where wbe=1 and old lanes elsewhere.
  - Memory is updated in both modes.
  - Different addresses: fully independent.
- Out-of-range addresses (address >= DEPTH, only possible when DEPTH < 2**ADDR):
  - A write is dropped.
  - A read returns 0 with rd_valid=1 at normal latency.
- Reset mid-operation: reads in flight are discarded, with no rd_valid for them. Memory contents written before reset are cleared only if CLR_ON_RST=1.
- Implementation constraints:
  - No combinational path from inputs to rd, rd_valid or busy.
  - Memory array has no reset other than the sweep.

Test Plan:
- Clear sweep (DEPTH=16, CLR_ON_RST=1): pulse rst for 2 cycles, then hold we=1 wbe=all-1 wd=0xFFFFFFFF during busy -> busy high exactly 16 cycles after rst falls; subsequent reads of addr 0..15 all return 0x00000000.
- Byte enables: write 0x11223344 full to addr 5, then wd=0xAABBCCDD wbe=4'b0101 to addr 5, read addr 5 -> rd=0x11BB33DD with rd_valid one cycle after re (OUT_REG=0).
- RDW (mem[7]=0x00000000, wd=0xDEADBEEF, wbe=4'b0011, re=we=1, addr 7):
  - RDW_MODE=0 -> rd=0x00000000.
  - RDW_MODE=1 -> rd=0x0000BEEF.
  - Following read of 7 in both modes -> 0x0000BEEF.
- Pipelining (OUT_REG=1): re=1 for 4 consecutive cycles on addrs 0,1,2,3 preloaded 0xA0..0xA3 -> rd_valid high 4 consecutive cycles starting 2 cycles after first re; rd=0xA0,0xA1,0xA2,0xA3; afterwards rd holds 0xA3 with rd_valid=0.
- Out of range (DEPTH=200, ADDR=8): write 0x5A5A5A5A to addr 210, read addr 210 -> rd=0, rd_valid=1; addr 199 read returns its own contents, unchanged.
- Reset mid-operation: assert rst while two OUT_REG=1 reads are in flight and again halfway through a clear sweep -> rd=0, rd_valid never pulses for the aborted reads, and busy stays high a full DEPTH cycles after the final rst deassertion.
